mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, the operand and HI/LO width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port start_i, input, 1: a valid multiply/divide-unit op is in the E stage.
REQ-005 SHALL have port op_i, input, 3: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have ports a_i and b_i, input, W each: rs and rt operands, forwarded values from E.
REQ-007 SHALL have port flush_i, input, 1: abort any in-flight op (exception or E-stage flush).
REQ-008 SHALL have port stall_o, output, 1: request to the hazard unit to stall F, D and E.
REQ-009 SHALL have port busy_o, output, 1: the iterative engine is occupied.
REQ-010 SHALL have port done_o, output, 1: one-cycle pulse when a MULT/DIV result is committed.
REQ-011 SHALL have ports hi_o and lo_o, output, W each: registered HI and LO.

Function
REQ-012 SHALL implement the states IDLE, MUL, DIV and DONE.
REQ-013 IDLE with start_i and MULT/MULTU SHALL go to MUL; with DIV/DIVU it SHALL go to DIV, latching |a|, |b| and sign flags.
REQ-014 IDLE with start_i and MTHI/MTLO SHALL write a_i to HI/LO at the next edge, with no stall and no state change.
REQ-015 stall_o SHALL be combinational: high in IDLE when start_i carries MULT/DIV, high throughout MUL/DIV, and low in DONE.
REQ-016 MUL SHALL perform one shift-add step per cycle for W cycles, then go to DONE.
REQ-017 DIV SHALL perform one restoring-divide step per cycle for W cycles, then go to DONE.
REQ-018 Latency: start accepted at cycle 0; HI/LO SHALL be written at the edge entering DONE (cycle W+1); done_o SHALL be high in DONE.
REQ-019 MULT SHALL produce the 2W-bit product with {HI,LO} = product; signed ops negate the result when the operand signs differ.
REQ-020 DIV SHALL produce LO = quotient and HI = remainder; the remainder takes the sign of a_i and the quotient is negated when the signs differ.
REQ-021 Division by zero SHALL give LO = all ones and HI = a_i, after the same full latency.
REQ-022 Signed DIV of -2^(W-1) by -1 SHALL give LO = -2^(W-1) and HI = 0.
REQ-023 DONE SHALL return to IDLE unconditionally; start_i in DONE SHALL be ignored.
REQ-024 start_i while in MUL or DIV SHALL be ignored.
REQ-025 flush_i in any state SHALL force IDLE at the next edge, leave HI/LO unchanged and deassert stall_o in the same cycle.
REQ-026 flush_i SHALL take priority over start_i, over MTHI/MTLO writes and over completion.
REQ-027 busy_o SHALL be high in MUL, DIV and DONE.

Reset
REQ-028 With rst low at an edge, the state SHALL become IDLE, HI and LO SHALL become 0, and all step counters SHALL become 0.
REQ-029 With rst low, stall_o, busy_o and done_o SHALL be 0; reset mid-operation SHALL discard the partial result.

Configuration
REQ-030 The macro MDU_DIV_EN SHALL control the divider.
REQ-031 With MDU_DIV_EN defined, DIV and DIVU SHALL behave as REQ-017 to REQ-022.
REQ-032 Without MDU_DIV_EN, DIV and DIVU SHALL be no-ops: no stall, HI/LO unchanged, and no divider logic synthesised.

Structure
REQ-033 Package mdu_pkg SHALL hold the op_i encodings, the state enum and the default W.
REQ-034 The per-cycle shift-add/subtract datapath SHALL be one sub-module, mdu_iter, sequenced by mdu_ctrl.

Verification
REQ-035 MULTU 0xFFFFFFFF x 2 -> stall_o high for cycles 0..32; HI=0x00000001, LO=0xFFFFFFFE at DONE; done_o pulses once.
REQ-036 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-037 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7.
REQ-038 MTHI 0x1234 then MTLO 0x5678 back to back -> no stall; hi_o=0x1234 and lo_o=0x5678 one cycle after each.
REQ-039 flush_i at cycle 10 of a MULT -> IDLE next cycle, stall_o low immediately, HI/LO keep prior values; rst low at cycle 5 of a DIV -> HI=LO=0.
REQ-040 Build without MDU_DIV_EN, issue DIV 9 / 3 -> stall_o never high, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op_i codes, FSM states, default width.
// The divider is only built when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mdu_iter.sv
// One-bit-per-cycle datapath: unsigned shift-add multiply and, with MDU_DIV_EN,
// restoring divide. acc/lo hold {partial product} or {remainder, quotient}.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
`ifdef MDU_DIV_EN
  input  logic         div_mode,
`endif
  input  logic [W-1:0] opnd_a,
  input  logic [W-1:0] opnd_b,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] lo_next
);

  logic [W-1:0] acc_reg;
  logic [W-1:0] lo_reg;
  logic [W-1:0] opnd_reg;
  logic [W:0]   sum;
`ifdef MDU_DIV_EN
  logic [W:0]   shifted;
  logic         fits;
`endif

  always_comb begin
    // Multiplier bits leave through lo[0] while product bits enter at lo[W-1].
    sum      = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    acc_next = sum[W:1];
    lo_next  = {sum[0], lo_reg[W-1:1]};
`ifdef MDU_DIV_EN
    shifted = {acc_reg, lo_reg[W-1]};
    fits    = shifted >= {1'b0, opnd_reg};
    if (div_mode) begin
      acc_next = fits ? (shifted[W-1:0] - opnd_reg) : shifted[W-1:0];
      lo_next  = {lo_reg[W-2:0], fits};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg  <= '0;
      lo_reg   <= '0;
      opnd_reg <= '0;
    end else if (load) begin
      acc_reg  <= '0;
      lo_reg   <= opnd_a;
      opnd_reg <= opnd_b;
    end else if (step) begin
      acc_reg <= acc_next;
      lo_reg  <= lo_next;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences mdu_iter over W cycles, applies sign
// fix-up and owns HI/LO. Divider present only when MDU_DIV_EN is defined.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         flush_i,
  output logic         stall_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   hi_reg;
  logic [W-1:0]   lo_reg;
  logic           neg_res_reg;
  logic           is_mul, is_div, signed_op, a_neg, b_neg, start_md, stepping;
  logic [W-1:0]   abs_a, abs_b, acc_next, lo_next;
  logic [2*W-1:0] prod_fix;
`ifdef MDU_DIV_EN
  logic           neg_rem_reg;
  logic           div_zero_reg;
  logic [W-1:0]   quo_fix, rem_fix;
`endif

  always_comb begin
    is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
`ifdef MDU_DIV_EN
    is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
`else
    is_div = 1'b0;
`endif
    signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg     = signed_op & a_i[W-1];
    b_neg     = signed_op & b_i[W-1];
    abs_a     = a_neg ? -a_i : a_i;
    abs_b     = b_neg ? -b_i : b_i;
    start_md  = (state_reg == ST_IDLE) && start_i && (is_mul || is_div) && !flush_i;
    stepping  = !flush_i && ((state_reg == ST_MUL) || (state_reg == ST_DIV));
    prod_fix  = neg_res_reg ? -{acc_next, lo_next} : {acc_next, lo_next};
`ifdef MDU_DIV_EN
    // Divide-by-zero naturally leaves |a| as remainder; only the quotient needs forcing.
    rem_fix = neg_rem_reg ? -acc_next : acc_next;
    quo_fix = div_zero_reg ? '1 : (neg_res_reg ? -lo_next : lo_next);
`endif
  end

  assign stall_o = rst && (start_md || stepping);
  assign busy_o  = rst && (state_reg != ST_IDLE);
  assign done_o  = rst && (state_reg == ST_DONE);
  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;

  mdu_iter #(.W(W)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (start_md),
    .step     (stepping),
`ifdef MDU_DIV_EN
    .div_mode (state_reg == ST_DIV),
`endif
    .opnd_a   (abs_a),
    .opnd_b   (abs_b),
    .acc_next (acc_next),
    .lo_next  (lo_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      neg_res_reg  <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
`endif
    end else if (flush_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            cnt_reg     <= '0;
            neg_res_reg <= a_neg ^ b_neg;
            if (is_mul) begin
              state_reg <= ST_MUL;
`ifdef MDU_DIV_EN
            end else if (is_div) begin
              state_reg    <= ST_DIV;
              neg_rem_reg  <= a_neg;
              div_zero_reg <= (b_i == '0);
`endif
            end else if (op_i == OP_MTHI) begin
              hi_reg <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo_reg <= a_i;
            end
          end
        end
        ST_MUL: begin
          if (cnt_reg == LAST) begin
            state_reg        <= ST_DONE;
            cnt_reg          <= '0;
            {hi_reg, lo_reg} <= prod_fix;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`ifdef MDU_DIV_EN
        ST_DIV: begin
          if (cnt_reg == LAST) begin
            state_reg <= ST_DONE;
            cnt_reg   <= '0;
            hi_reg    <= rem_fix;
            lo_reg    <= quo_fix;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised bench for mdu_ctrl against an arithmetic reference model of HI/LO,
// stall length and done timing; divide expectations follow MDU_DIV_EN.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [2:0]    op_i;
  logic [W-1:0]  a_i, b_i;
  logic          flush_i;
  logic          stall_o, busy_o, done_o;
  logic [W-1:0]  hi_o, lo_o;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_hi = '0;
  logic [W-1:0]  exp_lo = '0;

  mdu_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op on HI/LO; md=1 when it occupies the engine.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit md);
    longint       sa, sb;
    logic [63:0]  p;
    sa = $signed(a);
    sb = $signed(b);
    md = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb; {exp_hi, exp_lo} = p; md = 1'b1; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = p; md = 1'b1; end
      OP_MTHI:  exp_hi = a;
      OP_MTLO:  exp_lo = a;
`ifdef MDU_DIV_EN
      OP_DIV: begin
        md = 1'b1;
        if (b == '0) begin exp_lo = '1; exp_hi = a; end
        else begin p = sa / sb; exp_lo = p[31:0]; p = sa % sb; exp_hi = p[31:0]; end
      end
      OP_DIVU: begin
        md = 1'b1;
        if (b == '0) begin exp_lo = '1; exp_hi = a; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noisy);
    bit md;
    int nstall, ndone, done_cyc;
    model(op, a, b, md);
    nstall = 0; ndone = 0; done_cyc = -1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    for (int c = 0; c < W + 4; c++) begin
      #1;
      if (stall_o) nstall++;
      if (done_o) begin
        ndone++;
        done_cyc = c;
        check_val("done_hi", hi_o, exp_hi);
        check_val("done_lo", lo_o, exp_lo);
      end
      if (c == 1 && !md) begin
        check_val("quick_hi", hi_o, exp_hi);
        check_val("quick_lo", lo_o, exp_lo);
      end
      @(negedge clk);
      start_i = (md && noisy && c + 1 <= W + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      op_i = 3'($urandom_range(0, 5));
      a_i = $urandom; b_i = $urandom;
    end
    check_val("stall_cycles", 64'(nstall), md ? 64'(W + 1) : 64'd0);
    check_val("done_count", 64'(ndone), md ? 64'd1 : 64'd0);
    if (md) check_val("done_cycle", 64'(done_cyc), 64'(W + 1));
    check_val("end_hi", hi_o, exp_hi);
    check_val("end_lo", lo_o, exp_lo);
    check_val("end_busy", 64'(busy_o), 64'd0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h stall=%0d", op, a, b, hi_o, lo_o, nstall);
  endtask

  // Abort an op at cycle 'at' with flush (use_rst=0) or reset (use_rst=1).
  task automatic abort_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int at, input bit use_rst);
    int ndone;
    ndone = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    for (int c = 1; c <= at; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    if (use_rst) rst = 1'b0; else flush_i = 1'b1;
    #1;
    check_val("abort_stall", 64'(stall_o), 64'd0);
    if (use_rst) begin
      check_val("rst_busy", 64'(busy_o), 64'd0);
      check_val("rst_done", 64'(done_o), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b0;
    if (use_rst) begin exp_hi = '0; exp_lo = '0; end
    #1;
    check_val("abort_idle", 64'(busy_o), 64'd0);
    check_val("abort_nostall", 64'(stall_o), 64'd0);
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk); #1;
      if (done_o) ndone++;
    end
    check_val("abort_nodone", 64'(ndone), 64'd0);
    check_val("abort_hi", hi_o, exp_hi);
    check_val("abort_lo", lo_o, exp_lo);
    $display("abort op=%0d at=%0d rst=%0d -> hi=%h lo=%h", op, at, use_rst, hi_o, lo_o);
  endtask

  initial begin
    bit md;
    rst = 1'b0; start_i = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd4; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_stall", 64'(stall_o), 64'd0);
    check_val("rst_busy0", 64'(busy_o), 64'd0);
    check_val("rst_done0", 64'(done_o), 64'd0);
    check_val("rst_hi", hi_o, 64'd0);
    check_val("rst_lo", lo_o, 64'd0);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    #1;
    check_val("idle_busy", 64'(busy_o), 64'd0);
    $display("reset released hi=%h lo=%h", hi_o, lo_o);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(OP_MULT, -32'sd3, 32'd5, 1'b1);
    do_op(OP_DIV, -32'sd7, 32'd2, 1'b1);
    do_op(OP_DIVU, 32'd7, 32'd0, 1'b0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(OP_DIV, 32'd9, 32'd3, 1'b0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MTHI; a_i = 32'h1234; b_i = '0;
    model(OP_MTHI, 32'h1234, '0, md);
    #1;
    check_val("mthi_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    op_i = OP_MTLO; a_i = 32'h5678;
    #1;
    check_val("mthi_hi", hi_o, 64'h1234);
    check_val("mtlo_stall", 64'(stall_o), 64'd0);
    model(OP_MTLO, 32'h5678, '0, md);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check_val("mtlo_lo", lo_o, 64'h5678);
    $display("mthi/mtlo -> hi=%h lo=%h", hi_o, lo_o);

    abort_op(OP_MULT, 32'd1000, 32'd77, 10, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom_range(0, 5)), pick(), pick(), 1'($urandom_range(0, 1)));

    do_op(OP_MULT, 32'd3, 32'd5, 1'b0);
    abort_op(OP_DIV, 32'd100, 32'd7, 5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
